// File: rtl/midi_voice_ctrl_if.sv
// Byte stream in from the UART receiver, registered voice controls out.
// Master is the byte source / voice side, slave is the decoder.
interface midi_voice_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] note;
  logic       gate;
  logic [7:0] envelope_attack;
  logic [7:0] envelope_decay;
  logic       msg_strobe;

  modport master (
    output rx_data, rx_valid,
    input  note, gate, envelope_attack, envelope_decay, msg_strobe
  );

  modport slave (
    input  rx_data, rx_valid,
    output note, gate, envelope_attack, envelope_decay, msg_strobe
  );
endinterface

// File: rtl/midi_voice_ctrl.sv
// MIDI Note On/Off and CC decoder for one voice on one channel, with running status.
// Latency: outputs update one edge after the final data byte; no backpressure, one byte per rx_valid strobe.
module midi_voice_ctrl #(
  parameter int unsigned CHANNEL      = 0,
  parameter int unsigned ATTACK_CC    = 73,
  parameter int unsigned DECAY_CC     = 72,
  parameter logic [7:0]  ATTACK_RESET = 8'h10,
  parameter logic [7:0]  DECAY_RESET  = 8'h40
) (
  input  logic                clk,
  input  logic                rst,
  midi_voice_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SKIP, D1, D2} state_t;

  localparam logic [3:0] CH_NUM     = CHANNEL[3:0];
  localparam logic [6:0] ATK_NUM    = ATTACK_CC[6:0];
  localparam logic [6:0] DEC_NUM    = DECAY_CC[6:0];
  localparam logic [6:0] ALL_OFF_CC = 7'd123;
  localparam logic [3:0] TYPE_OFF   = 4'h8;
  localparam logic [3:0] TYPE_ON    = 4'h9;
  localparam logic [3:0] TYPE_CC    = 4'hB;

  state_t     state_q, state_d;
  logic [3:0] rs_q, rs_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic       gate_q, gate_d;
  logic [7:0] atk_q, atk_d;
  logic [7:0] dec_q, dec_d;
  logic       strobe_q, strobe_d;

  logic       is_sys, is_status, is_data, type_ok, apply;
  logic [6:0] d2;

  // Real-time bytes (F8-FF) match none of these and so fall through untouched.
  assign is_sys    = bus.rx_valid && (bus.rx_data[7:3] == 5'b11110);
  assign is_status = bus.rx_valid && bus.rx_data[7] && (bus.rx_data[7:4] != 4'hF);
  assign is_data   = bus.rx_valid && !bus.rx_data[7];
  assign type_ok   = (bus.rx_data[3:0] == CH_NUM) &&
                     ((bus.rx_data[7:4] == TYPE_OFF) || (bus.rx_data[7:4] == TYPE_ON) ||
                      (bus.rx_data[7:4] == TYPE_CC));
  assign apply     = is_data && (state_q == D2);
  assign d2        = bus.rx_data[6:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_sys) begin
      state_d = SKIP;
    end else if (is_status) begin
      state_d = type_ok ? D1 : SKIP;
    end else if (is_data) begin
      case (state_q)
        D1:      state_d = D2;
        D2:      state_d = D1;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rs_d     = rs_q;
    d1_d     = d1_q;
    note_d   = note_q;
    gate_d   = gate_q;
    atk_d    = atk_q;
    dec_d    = dec_q;
    strobe_d = 1'b0;
    if (is_sys) begin
      rs_d = 4'h0;
    end else if (is_status) begin
      rs_d = type_ok ? bus.rx_data[7:4] : 4'h0;
    end else if (is_data && (state_q == D1)) begin
      d1_d = bus.rx_data[6:0];
    end
    if (apply) begin
      strobe_d = 1'b1;
      if ((rs_q == TYPE_ON) && (d2 != 7'd0)) begin
        note_d = d1_q;
        gate_d = 1'b1;
      end else if ((rs_q == TYPE_ON) || (rs_q == TYPE_OFF)) begin
        // Last-note priority: only releasing the sounding note closes the gate.
        if (d1_q == note_q) gate_d = 1'b0;
      end else if (rs_q == TYPE_CC) begin
        if (d1_q == ATK_NUM)    atk_d  = {d2, d2[6]};
        if (d1_q == DEC_NUM)    dec_d  = {d2, d2[6]};
        if (d1_q == ALL_OFF_CC) gate_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q     <= 4'h0;
      d1_q     <= 7'd0;
      note_q   <= 7'd0;
      gate_q   <= 1'b0;
      atk_q    <= ATTACK_RESET;
      dec_q    <= DECAY_RESET;
      strobe_q <= 1'b0;
    end else begin
      rs_q     <= rs_d;
      d1_q     <= d1_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      atk_q    <= atk_d;
      dec_q    <= dec_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.note            = note_q;
  assign bus.gate            = gate_q;
  assign bus.envelope_attack = atk_q;
  assign bus.envelope_decay  = dec_q;
  assign bus.msg_strobe      = strobe_q;

endmodule

// File: doc/midi_voice_ctrl.md
Name: midi_voice_ctrl

Overview:
- MIDI byte-stream decoder that drives one synth voice's control inputs: note, gate, envelope_attack and envelope_decay.
- Sits between the UART RX byte output and a voice instance.
- Decodes Note On, Note Off and Control Change on one channel, including running status.
- All outputs are registered and held until a later message changes them.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) this instance responds to.
- ATTACK_CC, 73, CC number that writes envelope_attack.
- DECAY_CC, 72, CC number that writes envelope_decay.
- ATTACK_RESET, 8'h10, envelope_attack value at reset.
- DECAY_RESET, 8'h40, envelope_decay value at reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received MIDI byte.
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle.
- note  output  7  current MIDI note number to the voice.
- gate  output  1  voice gate; 1 = note held.
- envelope_attack  output  8  attack rate to the voice.
- envelope_decay  output  8  decay rate to the voice.
- msg_strobe  output  1  one-cycle pulse on each cycle an accepted message is applied.

Behaviour:
- Reset (rst=0, async): note=0, gate=0, envelope_attack=ATTACK_RESET, envelope_decay=DECAY_RESET, msg_strobe=0, state=IDLE, running status cleared.
- Bytes are consumed only when rx_valid=1, at most one per cycle. Cycles with rx_valid=0 change nothing except deasserting msg_strobe.
- Real-time bytes (F8-FF) are ignored entirely. State, running status and partial data are untouched, even mid-message.
- System common bytes (F0-F7) clear running status and go to SKIP. SysEx payload is discarded.
- Channel status byte (80-EF):
  - Any partial message is abandoned.
  - If channel == CHANNEL and type is 8 (off), 9 (on) or B (CC): latch type as running status, go to D1.
  - Otherwise: clear running status, go to SKIP.
- Data byte (bit7=0), by state:
  - IDLE: discard.
  - SKIP: discard.
  - D1: latch d1, go to D2.
  - D2: apply the message with d2, return to D1 (running status retained).
- Apply rules (registers update on the edge that accepts d2; msg_strobe=1 for exactly that following cycle):
  - Note On, d2!=0: note<=d1, gate<=1. If gate was already 1, this is legato: note changes and gate stays 1.
  - Note On with d2==0, or Note Off (any velocity): if d1==note then gate<=0; else no change. Last-note priority, no note stack.
  - CC ATTACK_CC: envelope_attack <= {d2, d2[6]}, giving a 7-to-8-bit full-scale map (0->00, 127->FF).
  - CC DECAY_CC: envelope_decay <= {d2, d2[6]}.
  - CC 123 (All Notes Off): gate<=0, note unchanged.
  - Any other CC: no output change, but msg_strobe still pulses.
  - If ATTACK_CC==DECAY_CC, both envelope registers are written.
- Latency: outputs are valid on the first clk edge after the edge that accepts the final data byte.
- Reset mid-message: partial message and running status are lost. The first data byte after reset is discarded (state is IDLE).

Test Plan:
- Reset values: hold rst=0 then release -> note=0, gate=0, attack=8'h10, decay=8'h40, msg_strobe=0.
- Basic on/off on ch0: send 90 3C 64 -> next cycle note=60, gate=1, msg_strobe pulse. Then send 80 3C 00 -> gate=0, note stays 60.
- Running status with vel-0 off: send 90 40 7F, 43 7F, 40 00 -> note=67 with gate=1 after the second pair. The third pair (40 00) leaves gate=1 because 64 != 67. Then send 43 00 -> gate=0.
- Channel filter and interruption: send 91 3C 64 (ch1) -> no change, no strobe. Send 90 3C F8 64 -> note=60, gate=1 (real-time byte ignored). Send 90 3E B0 -> partial message dropped; then 49 7F -> attack=8'hFF.
- CC scaling: send B0 48 00 -> decay=00. Send B0 48 40 -> decay=8'h81. Send B0 7B 00 while gate=1 -> gate=0.
- SysEx and async reset: send F0 3C 64 F7 -> no change. Assert rst between 90 and 3C -> outputs return to reset values immediately; then 3C 64 alone -> no change.
